serial_add_ctrl: RTL and testbench

//  Bit-serial adder controller: sequences one 1-bit full_adder_df slice over WIDTH

---
 rtl/serial_add_ctrl_if.sv | 37 +++
 rtl/serial_add_ctrl.sv | 129 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle between a requester and the bit-serial adder controller.
// SERIAL_ADD_OVF_EN adds the signed-overflow flag to the bundle.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, ovf
  );
`else
  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
`endif
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one shared 1-bit full-adder slice stepped over WIDTH cycles.
// Optional feature macro: SERIAL_ADD_OVF_EN (signed-overflow flag output).
module full_adder_df (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);
  assign o_sum  = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_add_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;
`ifdef SERIAL_ADD_OVF_EN
  logic             r_ovf;
`endif

  logic             w_fa_sum;
  logic             w_fa_cout;
  logic [WIDTH-1:0] w_sum_shift;

  full_adder_df u_fa (
    .i_a    (r_a[0]),
    .i_b    (r_b[0]),
    .i_cin  (r_carry),
    .o_sum  (w_fa_sum),
    .o_cout (w_fa_cout)
  );

  // Result fills from the MSB end, so after WIDTH steps bit 0 lands at the LSB.
  generate
    if (WIDTH == 1) begin : g_sum_w1
      assign w_sum_shift = w_fa_sum;
    end else begin : g_sum_wn
      assign w_sum_shift = {w_fa_sum, r_sum[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_carry <= bus.cin;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_sum   <= w_sum_shift;
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_carry <= w_fa_cout;
          if (r_cnt == CNT_LAST) begin
            r_cout  <= w_fa_cout;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
`ifdef SERIAL_ADD_OVF_EN
            // r_carry here is the carry into the MSB slice.
            r_ovf   <= r_carry ^ w_fa_cout;
`endif
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
`ifdef SERIAL_ADD_OVF_EN
  assign bus.ovf  = r_ovf;
`endif
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl (WIDTH=8 and WIDTH=1 instances) with a result scoreboard.
module tb_serial_add_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  serial_add_ctrl_if #(.WIDTH(8)) bus8 ();
  serial_add_ctrl_if #(.WIDTH(1)) bus1 ();

  serial_add_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_add_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  typedef struct packed {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One WIDTH=8 operation; called at a negedge, returns at the negedge after DONE.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input bit hold);
    exp_t       e;
    exp_t       got_e;
    logic [8:0] full;
    int         busy_n;
    bit         got;
    full   = {1'b0, a} + {1'b0, b} + {8'b0, cin};
    e.sum  = full[7:0];
    e.cout = full[8];
    e.ovf  = (a[7] == b[7]) && (full[7] != a[7]);
    bus8.a     = a;
    bus8.b     = b;
    bus8.cin   = cin;
    bus8.start = 1'b1;
    sb.push_back(e);
    busy_n = 0;
    got    = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (!hold && i == 0) bus8.start = 1'b0;
      if (i == 3) begin
        bus8.a   = ~a;
        bus8.b   = a ^ 8'h33;
        bus8.cin = ~cin;
      end
      if (bus8.done) begin
        check({tag, " latency"}, i, 8);
        check({tag, " busy_at_done"}, {31'b0, bus8.busy}, 0);
        got_e = sb.pop_front();
        check({tag, " sum"}, {24'b0, bus8.sum}, {24'b0, got_e.sum});
        check({tag, " cout"}, {31'b0, bus8.cout}, {31'b0, got_e.cout});
`ifdef SERIAL_ADD_OVF_EN
        check({tag, " ovf"}, {31'b0, bus8.ovf}, {31'b0, got_e.ovf});
`endif
        got = 1'b1;
        break;
      end
      if (bus8.busy) busy_n++;
    end
    if (!got) begin
      check({tag, " done_timeout"}, {31'b0, bus8.done}, 1);
      sb.delete();
    end
    check({tag, " busy_cycles"}, busy_n, 8);
    @(negedge clk);
    check({tag, " done_one_cycle"}, {31'b0, bus8.done}, 0);
    check({tag, " idle_after_done"}, {31'b0, bus8.busy}, 0);
    $display("op %s: a=%02h b=%02h cin=%0d -> sum=%02h cout=%0d", tag, a, b, cin, bus8.sum, bus8.cout);
  endtask

  initial begin
    exp_t       e;
    logic [1:0] f;
    int         done_n;
    rst_n      = 1'b0;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;
    repeat (2) @(negedge clk);
    check("rst busy", {31'b0, bus8.busy}, 0);
    check("rst done", {31'b0, bus8.done}, 0);
    check("rst sum", {24'b0, bus8.sum}, 0);
    check("rst cout", {31'b0, bus8.cout}, 0);
    check("rst w1 busy", {31'b0, bus1.busy}, 0);
`ifdef SERIAL_ADD_OVF_EN
    check("rst ovf", {31'b0, bus8.ovf}, 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    run_op("T1", 8'h5A, 8'h3C, 1'b0, 1'b0);
    run_op("T2a", 8'hFF, 8'h01, 1'b0, 1'b0);
    run_op("T2b", 8'hFF, 8'hFF, 1'b1, 1'b0);

    // Start held high throughout: second op must be taken on the first IDLE cycle.
    run_op("T3a", 8'h12, 8'h34, 1'b1, 1'b1);
    run_op("T3b", 8'hA5, 8'h6C, 1'b0, 1'b1);
    bus8.start = 1'b0;

    // Mid-operation async reset.
    bus8.a = 8'hC3; bus8.b = 8'h5A; bus8.cin = 1'b1; bus8.start = 1'b1;
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (i == 0) bus8.start = 1'b0;
    end
    check("T4 busy_before_rst", {31'b0, bus8.busy}, 1);
    #1 rst_n = 1'b0;
    #1;
    check("T4 rst busy", {31'b0, bus8.busy}, 0);
    check("T4 rst done", {31'b0, bus8.done}, 0);
    check("T4 rst sum", {24'b0, bus8.sum}, 0);
    check("T4 rst cout", {31'b0, bus8.cout}, 0);
    @(negedge clk);
    rst_n  = 1'b1;
    done_n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus8.done) done_n++;
    end
    check("T4 no_done_after_abort", done_n, 0);
    $display("op T4: reset abort, done pulses seen=%0d", done_n);
    run_op("T4r", 8'h81, 8'h7E, 1'b1, 1'b0);

    run_op("T5a", 8'h7F, 8'h01, 1'b0, 1'b0);
    run_op("T5b", 8'h80, 8'hFF, 1'b0, 1'b0);
    run_op("T5c", 8'h10, 8'h20, 1'b0, 1'b0);

    // WIDTH=1 full-adder truth table.
    for (int k = 0; k < 8; k++) begin
      bus1.a     = k[2];
      bus1.b     = k[1];
      bus1.cin   = k[0];
      bus1.start = 1'b1;
      f      = {1'b0, k[2]} + {1'b0, k[1]} + {1'b0, k[0]};
      e.sum  = {7'b0, f[0]};
      e.cout = f[1];
      e.ovf  = 1'b0;
      sb.push_back(e);
      @(negedge clk);
      bus1.start = 1'b0;
      check("T6 run_busy", {31'b0, bus1.busy}, 1);
      check("T6 run_done", {31'b0, bus1.done}, 0);
      @(negedge clk);
      check("T6 done", {31'b0, bus1.done}, 1);
      if (bus1.done) begin
        e = sb.pop_front();
        check("T6 sum", {31'b0, bus1.sum}, {31'b0, e.sum[0]});
        check("T6 cout", {31'b0, bus1.cout}, {31'b0, e.cout});
      end
      $display("op T6[%0d]: a=%0d b=%0d cin=%0d -> sum=%0d cout=%0d", k, k[2], k[1], k[0], bus1.sum, bus1.cout);
      @(negedge clk);
      check("T6 done_one_cycle", {31'b0, bus1.done}, 0);
    end
    sb.delete();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
